dff_seq_ctrl: RTL and testbench
===============================

DFF_SEQ_CTRL -- requirements
Module: dff_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 8, data width of the sequenced register datapath.
REQ-002 Parameter DEPTH, default 4, number of pattern entries (power of two).
REQ-003 Parameter LAT, default 1, din-to-dout latency of the controlled register, legal range 1..4.
REQ-004 clk  input  1  single clock; all logic on posedge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 cfg_we  input  1  pattern-memory write strobe.
REQ-007 cfg_addr  input  log2(DEPTH)  pattern-memory write index.
REQ-008 cfg_data  input  WIDTH  pattern-memory write value.
REQ-009 len  input  log2(DEPTH)  run length minus one; sampled at start acceptance.
REQ-010 start  input  1  run request, level-sampled.
REQ-011 din  output  WIDTH  registered data driven into the register datapath.
REQ-012 dout  input  WIDTH  register datapath output, compared against the pattern.
REQ-013 busy  output  1  run in progress.
REQ-014 done  output  1  one-cycle end-of-run pulse.
REQ-015 pass  output  1  result of the last completed run.
REQ-016 err_cnt  output  4  mismatches in the current or last run.

Function
REQ-017 The FSM SHALL have states IDLE, DRIVE, DRAIN and FIN.
REQ-018 IDLE with start=1 SHALL latch len, clear err_cnt and pass, and go to DRIVE.
REQ-019 DRIVE SHALL last len+1 cycles, with din=pat[k] registered in the k-th DRIVE cycle, k=0..len.
REQ-020 After the last DRIVE cycle the FSM SHALL enter DRAIN for exactly LAT cycles, then FIN for one cycle, then return to IDLE.
REQ-021 din SHALL be 0 in all states other than DRIVE.
REQ-022 An expected-value/valid delay line of depth LAT SHALL compare dout with pat[k] exactly LAT cycles after din=pat[k].
REQ-023 Each valid compare with dout != expected SHALL increment err_cnt, saturating at 15.
REQ-024 busy SHALL be 1 in DRIVE and DRAIN and 0 otherwise.
REQ-025 done SHALL be 1 only in FIN.
REQ-026 pass SHALL be set in FIN to (err_cnt==0 including the final compare), and SHALL hold until the next accepted start.
REQ-027 start while not in IDLE SHALL be ignored; start held high in IDLE after FIN SHALL begin a new run.
REQ-028 cfg_we SHALL write pat[cfg_addr] only in IDLE and SHALL be ignored otherwise.
REQ-029 cfg_we and start asserted in the same IDLE cycle SHALL both take effect, and the run SHALL use the newly written value.
REQ-030 The done pulse SHALL occur in cycle (accept cycle)+len+LAT+2.
REQ-031 Pattern contents SHALL be preserved across runs and across reset.

Reset
REQ-032 rst=1 SHALL force state=IDLE, din=0, busy=0, done=0, pass=0, err_cnt=0 and clear the delay line at the next edge.
REQ-033 rst during DRIVE or DRAIN SHALL abort the run without a done pulse, and no compare SHALL be counted after reset.
REQ-034 rst SHALL take priority over start and cfg_we.

Verification
REQ-035 With LAT=1, a correct 1-cycle register, pat={1,2,3}, len=2 and start: din shows 1,2,3 on consecutive cycles, done at accept+5, pass=1, err_cnt=0.
REQ-036 Same as REQ-035 with dout forced to 0 throughout: err_cnt=3 and pass=0 at done.
REQ-037 With len=3, pat={FF,00,A5,5A} and dout stuck at A5 for the whole run: err_cnt=3 and pass=0.
REQ-038 Assert rst in the second DRIVE cycle: busy=0 and din=0 the next cycle, no done pulse, err_cnt=0; a following run passes.
REQ-039 Pulse start and cfg_we (addr 0, data 7E) during a run: both are ignored, pat[0] is unchanged, and the run completes once.
REQ-040 With LAT=3 and a 3-stage delay model, len=0 and pat[0]=3C: done at accept+5, pass=1.

Source files
------------

// File: rtl/dff_seq_ctrl_if.sv
// Bus bundle between the sequence controller and its test environment:
// pattern configuration, run control, datapath drive/return and status.
interface dff_seq_ctrl_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic             cfg_we;
  logic [AW-1:0]    cfg_addr;
  logic [WIDTH-1:0] cfg_data;
  logic [AW-1:0]    len;
  logic             start;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic             busy;
  logic             done;
  logic             pass;
  logic [3:0]       err_cnt;

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, len, start, dout,
    output din, busy, done, pass, err_cnt
  );

  modport master (
    output cfg_we, cfg_addr, cfg_data, len, start, dout,
    input  din, busy, done, pass, err_cnt
  );
endinterface

// File: rtl/dff_seq_ctrl.sv
// Drives a stored pattern into a register datapath of latency LAT and checks
// the returned data, reporting a saturating mismatch count and pass flag.
module dff_seq_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LAT   = 1
) (
  input  logic           clk,
  input  logic           rst,
  dff_seq_ctrl_if.slave  bus
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = 3;
  localparam int unsigned EW = 4;

  typedef enum logic [1:0] {IDLE, DRIVE, DRAIN, FIN} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_pat [DEPTH];
  logic [AW-1:0]    r_len;
  logic [AW-1:0]    r_idx;
  logic [CW-1:0]    r_drn;
  logic [WIDTH-1:0] r_din;
  logic             r_din_vld;
  logic [WIDTH-1:0] r_exp [LAT];
  logic             r_vld [LAT];
  logic             r_busy;
  logic             r_done;
  logic             r_pass;
  logic [EW-1:0]    r_err;

  logic             w_accept;
  logic             w_pat_wr;
  logic [AW-1:0]    w_pat_idx;
  logic [WIDTH-1:0] w_pat_val;
  logic             w_mis;
  logic [EW-1:0]    w_err_nxt;

  // Next-state and datapath steering
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      IDLE:  if (bus.start) begin
               w_state_nxt = DRIVE;
               w_accept    = 1'b1;
             end
      DRIVE: if (r_idx == r_len) w_state_nxt = DRAIN;
      DRAIN: if (r_drn == CW'(LAT - 1)) w_state_nxt = FIN;
      FIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase

    w_pat_wr  = (r_state == IDLE) && bus.cfg_we;
    w_pat_idx = w_accept ? '0 : r_idx + 1'b1;
    // A write in the accept cycle must be visible to the run it starts
    w_pat_val = (w_pat_wr && (bus.cfg_addr == w_pat_idx)) ? bus.cfg_data : r_pat[w_pat_idx];

    w_mis     = r_vld[LAT-1] && (bus.dout != r_exp[LAT-1]);
    w_err_nxt = (w_mis && (r_err != '1)) ? r_err + 1'b1 : r_err;
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Pattern memory is deliberately not reset
  always_ff @(posedge clk) begin
    if (!rst && w_pat_wr) r_pat[bus.cfg_addr] <= bus.cfg_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_din     <= '0;
      r_din_vld <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_err     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_drn     <= '0;
      for (int j = 0; j < int'(LAT); j++) begin
        r_exp[j] <= '0;
        r_vld[j] <= 1'b0;
      end
    end else begin
      r_din     <= (w_state_nxt == DRIVE) ? w_pat_val : '0;
      r_din_vld <= (w_state_nxt == DRIVE);
      r_busy    <= (w_state_nxt == DRIVE) || (w_state_nxt == DRAIN);
      r_done    <= (w_state_nxt == FIN);
      r_drn     <= (r_state == DRAIN) ? r_drn + 1'b1 : '0;

      // Expected values trail din by LAT cycles to line up with dout
      r_exp[0] <= r_din;
      r_vld[0] <= r_din_vld;
      for (int j = 1; j < int'(LAT); j++) begin
        r_exp[j] <= r_exp[j-1];
        r_vld[j] <= r_vld[j-1];
      end

      if (w_accept) begin
        r_len  <= bus.len;
        r_idx  <= '0;
        r_err  <= '0;
        r_pass <= 1'b0;
      end else begin
        r_err <= w_err_nxt;
        if (r_state == DRIVE) r_idx <= r_idx + 1'b1;
      end

      if ((r_state == DRAIN) && (w_state_nxt == FIN)) r_pass <= (w_err_nxt == '0);
    end
  end

  assign bus.din     = r_din;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.pass    = r_pass;
  assign bus.err_cnt = r_err;
endmodule

// File: tb/tb_dff_seq_ctrl.sv
// Runs two controllers (LAT=1 and LAT=3) in lockstep against behavioural
// register models and a run-level reference of din timing and error counts.
module tb_dff_seq_ctrl;
  localparam int unsigned LATA = 1;
  localparam int unsigned LATB = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_we;
  logic [1:0] cfg_addr;
  logic [7:0] cfg_data;
  logic [1:0] len;
  logic       start;

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         c0;
  int         mode;
  logic [7:0] stk;
  logic [7:0] mpat [4];
  logic [7:0] mask_cur;
  logic [7:0] mask_hist [256];
  logic [7:0] dly_a;
  logic [7:0] dly_b [3];

  dff_seq_ctrl_if #(.WIDTH(8), .DEPTH(4)) ifa ();
  dff_seq_ctrl_if #(.WIDTH(8), .DEPTH(4)) ifb ();

  dff_seq_ctrl #(.WIDTH(8), .DEPTH(4), .LAT(LATA)) u_dut_a (.clk(clk), .rst(rst), .bus(ifa));
  dff_seq_ctrl #(.WIDTH(8), .DEPTH(4), .LAT(LATB)) u_dut_b (.clk(clk), .rst(rst), .bus(ifb));

  always #5 clk = ~clk;

  assign ifa.cfg_we = cfg_we;   assign ifb.cfg_we = cfg_we;
  assign ifa.cfg_addr = cfg_addr; assign ifb.cfg_addr = cfg_addr;
  assign ifa.cfg_data = cfg_data; assign ifb.cfg_data = cfg_data;
  assign ifa.len = len;         assign ifb.len = len;
  assign ifa.start = start;     assign ifb.start = start;

  // Environment register models: plain delay, stuck value, or delay with corruption
  assign ifa.dout = (mode == 1) ? stk : (mode == 2) ? (dly_a ^ mask_cur) : dly_a;
  assign ifb.dout = (mode == 1) ? stk : (mode == 2) ? (dly_b[2] ^ mask_cur) : dly_b[2];

  always @(posedge clk) begin
    int m;
    m = (mode == 2 && $urandom_range(0, 2) == 0) ? int'($urandom_range(1, 255)) : 0;
    cyc <= cyc + 1;
    mask_cur <= 8'(m);
    mask_hist[8'(cyc + 1)] <= 8'(m);
    dly_a <= ifa.din;
    dly_b[0] <= ifb.din;
    dly_b[1] <= dly_b[0];
    dly_b[2] <= dly_b[1];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Errors the run should accumulate: each element whose returned value differs
  function automatic int model_err(input int lat, input int ln);
    int e = 0;
    logic [7:0] seen;
    for (int k = 0; k <= ln; k++) begin
      case (mode)
        0:       seen = mpat[k];
        1:       seen = stk;
        default: seen = mpat[k] ^ mask_hist[8'(c0 + 1 + k + lat)];
      endcase
      if (seen != mpat[k] && e < 15) e++;
    end
    return e;
  endfunction

  task automatic exp_cycle(input string nm, input int lat, input int t, input int ln, input int rst_at,
                           input logic [7:0] o_din, input logic o_busy, input logic o_done,
                           input logic o_pass, input logic [3:0] o_err);
    int dn = ln + lat + 2;
    int e;
    if (rst_at > 0 && t > rst_at) begin
      check_eq({nm, ".abort.din"}, 32'(o_din), 32'd0);
      check_eq({nm, ".abort.busy"}, 32'(o_busy), 32'd0);
      check_eq({nm, ".abort.done"}, 32'(o_done), 32'd0);
      check_eq({nm, ".abort.err"}, 32'(o_err), 32'd0);
      check_eq({nm, ".abort.pass"}, 32'(o_pass), 32'd0);
    end else begin
      check_eq({nm, ".din"}, 32'(o_din), (t >= 1 && t <= ln + 1) ? 32'(mpat[t-1]) : 32'd0);
      check_eq({nm, ".busy"}, 32'(o_busy), 32'(t >= 1 && t <= ln + 1 + lat));
      check_eq({nm, ".done"}, 32'(o_done), 32'(t == dn));
      if (t >= dn) begin
        e = model_err(lat, ln);
        check_eq({nm, ".err_cnt"}, 32'(o_err), 32'(e));
        check_eq({nm, ".pass"}, 32'(o_pass), 32'(e == 0));
      end else begin
        check_eq({nm, ".pass_clr"}, 32'(o_pass), 32'd0);
      end
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    mpat[a] = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
  endtask

  // One run from accept to a few idle cycles past the later done pulse
  task automatic run_seq(input int ln, input int md, input logic [7:0] sv, input bit same_wr,
                         input int ign_at, input int rst_at);
    mode = md; stk = sv;
    @(posedge clk); #1;
    c0 = cyc;
    start = 1'b1; len = 2'(ln);
    if (same_wr) begin
      cfg_we = 1'b1;
      cfg_addr = 2'($urandom_range(0, ln));
      cfg_data = 8'($urandom);
      mpat[cfg_addr] = cfg_data;
    end
    for (int t = 1; t <= ln + int'(LATB) + 4; t++) begin
      @(posedge clk); #1;
      start = 1'b0; cfg_we = 1'b0; rst = 1'b0;
      if (t == ign_at) begin
        start = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd0; cfg_data = 8'h7E;
      end
      if (t == rst_at) rst = 1'b1;
      @(negedge clk);
      exp_cycle("A", int'(LATA), t, ln, rst_at, ifa.din, ifa.busy, ifa.done, ifa.pass, ifa.err_cnt);
      exp_cycle("B", int'(LATB), t, ln, rst_at, ifb.din, ifb.busy, ifb.done, ifb.pass, ifb.err_cnt);
    end
    rst = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    @(negedge clk);
    check_eq({tag, ".A.din"}, 32'(ifa.din), 32'd0);
    check_eq({tag, ".A.busy"}, 32'(ifa.busy), 32'd0);
    check_eq({tag, ".A.done"}, 32'(ifa.done), 32'd0);
    check_eq({tag, ".A.pass"}, 32'(ifa.pass), 32'd0);
    check_eq({tag, ".A.err"}, 32'(ifa.err_cnt), 32'd0);
    check_eq({tag, ".B.din"}, 32'(ifb.din), 32'd0);
    check_eq({tag, ".B.busy"}, 32'(ifb.busy), 32'd0);
    check_eq({tag, ".B.pass"}, 32'(ifb.pass), 32'd0);
    check_eq({tag, ".B.err"}, 32'(ifb.err_cnt), 32'd0);
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0; len = '0; start = 1'b0;
    mode = 0; stk = '0;
    repeat (3) @(posedge clk);
    check_idle_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    cfg_write(2'd0, 8'h01); cfg_write(2'd1, 8'h02); cfg_write(2'd2, 8'h03); cfg_write(2'd3, 8'h04);
    run_seq(2, 0, 8'h00, 1'b0, 0, 0);
    run_seq(2, 1, 8'h00, 1'b0, 0, 0);

    cfg_write(2'd0, 8'hFF); cfg_write(2'd1, 8'h00); cfg_write(2'd2, 8'hA5); cfg_write(2'd3, 8'h5A);
    run_seq(3, 1, 8'hA5, 1'b0, 0, 0);

    // Reset wins over a simultaneous pattern write and clears status
    @(posedge clk); #1;
    rst = 1'b1; cfg_we = 1'b1; cfg_addr = 2'd1; cfg_data = 8'hEE;
    @(posedge clk); #1;
    rst = 1'b0; cfg_we = 1'b0;
    check_idle_zero("rst_vs_cfg");

    run_seq(3, 0, 8'h00, 1'b0, 0, 0);
    run_seq(3, 0, 8'h00, 1'b0, 0, 2);
    run_seq(3, 0, 8'h00, 1'b0, 0, 0);
    run_seq(3, 0, 8'h00, 1'b0, 2, 0);
    run_seq(3, 2, 8'h00, 1'b0, 0, 0);

    cfg_write(2'd0, 8'h3C);
    run_seq(0, 0, 8'h00, 1'b0, 0, 0);
    run_seq(1, 0, 8'h00, 1'b1, 0, 0);

    for (int i = 0; i < 14; i++) begin
      if ($urandom_range(0, 1) == 1) cfg_write(2'($urandom), 8'($urandom));
      run_seq(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), 8'($urandom),
              1'($urandom_range(0, 1)), 0, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
